// File: rtl/multicycle_pkg.sv
// rtl/multicycle_pkg.sv - shared encodings for the multicycle RV32I controller
package multicycle_pkg;

    typedef logic [3:0] state_t;

    localparam state_t S_FETCH    = 4'd0;
    localparam state_t S_DECODE   = 4'd1;
    localparam state_t S_MEMADR   = 4'd2;
    localparam state_t S_MEMREAD  = 4'd3;
    localparam state_t S_MEMWB    = 4'd4;
    localparam state_t S_MEMWRITE = 4'd5;
    localparam state_t S_EXECUTER = 4'd6;
    localparam state_t S_EXECUTEI = 4'd7;
    localparam state_t S_ALUWB    = 4'd8;
    localparam state_t S_BEQ      = 4'd9;
    localparam state_t S_JAL      = 4'd10;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALUC_ADD = 3'b000;
    localparam logic [2:0] ALUC_SUB = 3'b001;
    localparam logic [2:0] ALUC_AND = 3'b010;
    localparam logic [2:0] ALUC_OR  = 3'b011;
    localparam logic [2:0] ALUC_SLT = 3'b101;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/multicycle_alu_decoder.sv
// rtl/multicycle_alu_decoder.sv - maps ALUOp/funct fields to an ALU operation
module multicycle_alu_decoder
    import multicycle_pkg::*;
(
    input  logic       i_op5,
    input  logic       i_fn7,
    input  logic [2:0] i_fn3,
    input  logic [1:0] i_alu_op,
    output logic [2:0] o_alu_control
);

    always_comb begin
        o_alu_control = ALUC_ADD;
        case (i_alu_op)
            ALUOP_SUB: o_alu_control = ALUC_SUB;
            ALUOP_FUNCT: begin
                case (i_fn3)
                    // Only R-type uses fn7 to select sub; addi ignores it.
                    3'b000:  o_alu_control = (i_op5 && i_fn7) ? ALUC_SUB : ALUC_ADD;
                    3'b010:  o_alu_control = ALUC_SLT;
                    3'b110:  o_alu_control = ALUC_OR;
                    3'b111:  o_alu_control = ALUC_AND;
                    default: o_alu_control = ALUC_ADD;
                endcase
            end
            default: o_alu_control = ALUC_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - 11-state sequencer driving the shared-memory RV32I datapath
module multicycle_controller
    import multicycle_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] fn3,
    input  logic       fn7,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       InstrDone,
    output logic       Illegal
);

    state_t     r_state;
    state_t     w_next;
    logic [1:0] w_alu_op;
    logic       w_pc_write, w_ir_write, w_mem_write, w_reg_write, w_done, w_illegal;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_FETCH;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next      = S_FETCH;
        w_alu_op    = ALUOP_ADD;
        w_pc_write  = 1'b0;
        w_ir_write  = 1'b0;
        w_mem_write = 1'b0;
        w_reg_write = 1'b0;
        w_done      = 1'b0;
        w_illegal   = 1'b0;
        AdrSrc      = 1'b0;
        ResultSrc   = RES_ALUOUT;
        ALUSrcA     = SRCA_PC;
        ALUSrcB     = SRCB_RD2;
        ImmSrc      = IMM_I;
        case (r_state)
            S_FETCH: begin
                ALUSrcB    = SRCB_FOUR;
                ResultSrc  = RES_ALURESULT;
                w_ir_write = mem_ready;
                w_pc_write = mem_ready;
                w_next     = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // ALU precomputes the branch target from OldPC while we decode.
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = IMM_B;
                case (op)
                    OP_LOAD, OP_STORE: w_next = S_MEMADR;
                    OP_RTYPE:          w_next = S_EXECUTER;
                    OP_ITYPE:          w_next = S_EXECUTEI;
                    OP_BRANCH:         w_next = S_BEQ;
                    OP_JAL:            w_next = S_JAL;
                    default: begin
                        w_next    = S_FETCH;
                        w_illegal = 1'b1;
                        w_done    = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = op[5] ? IMM_S : IMM_I;
                w_next  = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                w_next = mem_ready ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                ResultSrc   = RES_DATA;
                w_reg_write = 1'b1;
                w_done      = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc      = 1'b1;
                w_mem_write = 1'b1;
                w_done      = mem_ready;
                w_next      = mem_ready ? S_FETCH : S_MEMWRITE;
            end
            S_EXECUTER: begin
                ALUSrcA  = SRCA_RD1;
                w_alu_op = ALUOP_FUNCT;
                w_next   = S_ALUWB;
            end
            S_EXECUTEI: begin
                ALUSrcA  = SRCA_RD1;
                ALUSrcB  = SRCB_IMM;
                w_alu_op = ALUOP_FUNCT;
                w_next   = S_ALUWB;
            end
            S_ALUWB: begin
                w_reg_write = 1'b1;
                w_done      = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA    = SRCA_RD1;
                w_alu_op   = ALUOP_SUB;
                w_pc_write = Zero;
                w_done     = 1'b1;
            end
            S_JAL: begin
                ALUSrcA    = SRCA_OLDPC;
                ALUSrcB    = SRCB_FOUR;
                w_pc_write = 1'b1;
                w_next     = S_ALUWB;
            end
            default: w_next = S_FETCH;
        endcase
    end

    // Enables are masked by reset so they drop without waiting for a clock edge.
    assign PCWrite   = rst & w_pc_write;
    assign IRWrite   = rst & w_ir_write;
    assign MemWrite  = rst & w_mem_write;
    assign RegWrite  = rst & w_reg_write;
    assign InstrDone = rst & w_done;
    assign Illegal   = rst & w_illegal;

    multicycle_alu_decoder u_alu_decoder (
        .i_op5         (op[5]),
        .i_fn7         (fn7),
        .i_fn3         (fn3),
        .i_alu_op      (w_alu_op),
        .o_alu_control (ALUControl)
    );

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - self-checking bench for multicycle_controller
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] op;
    logic [2:0] fn3;
    logic       fn7;
    logic       Zero;
    logic       mem_ready;
    logic       PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, InstrDone, Illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;

    multicycle_controller dut (
        .clk(clk), .rst(rst), .op(op), .fn3(fn3), .fn7(fn7), .Zero(Zero),
        .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
        .MemWrite(MemWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
        .ALUControl(ALUControl), .InstrDone(InstrDone), .Illegal(Illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       mr;
        logic       z;
        logic       pcw;
        logic       adr;
        logic       irw;
        logic       memw;
        logic       regw;
        logic [1:0] res;
        logic [1:0] asa;
        logic [1:0] asb;
        logic [1:0] imm;
        logic [2:0] aluc;
        logic       done;
        logic       ill;
    } exp_t;

    exp_t  q[$];
    exp_t  cur;
    logic  cur_valid = 1'b0;
    string cur_tag = "";
    int    n_checks = 0;
    int    n_errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s %s: got %0h expected %0h at %0t", cur_tag, name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cur_valid) begin
            chk("PCWrite",    PCWrite,    cur.pcw);
            chk("AdrSrc",     AdrSrc,     cur.adr);
            chk("IRWrite",    IRWrite,    cur.irw);
            chk("MemWrite",   MemWrite,   cur.memw);
            chk("RegWrite",   RegWrite,   cur.regw);
            chk("ResultSrc",  ResultSrc,  cur.res);
            chk("ALUSrcA",    ALUSrcA,    cur.asa);
            chk("ALUSrcB",    ALUSrcB,    cur.asb);
            chk("ImmSrc",     ImmSrc,     cur.imm);
            chk("ALUControl", ALUControl, cur.aluc);
            chk("InstrDone",  InstrDone,  cur.done);
            chk("Illegal",    Illegal,    cur.ill);
        end
    end

    // Expected ALU operation for an R/I arithmetic instruction, from its meaning.
    function automatic logic [2:0] model_alu(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        case (f3)
            3'b000:  return (o == 7'b0110011 && f7) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic exp_t blank(input logic mr, input logic z);
        exp_t e = '0;
        e.mr = mr;
        e.z  = z;
        return e;
    endfunction

    // Expand one instruction into its expected per-cycle outputs.
    task automatic build(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                         input logic z, input int fetch_wait, input int mem_wait);
        exp_t e;
        q.delete();
        for (int i = 0; i <= fetch_wait; i++) begin
            e = blank(i == fetch_wait, z);
            e.asb = 2'b10; e.res = 2'b10;
            e.irw = e.mr;  e.pcw = e.mr;
            q.push_back(e);
        end
        e = blank(1'b1, z);
        e.asa = 2'b01; e.asb = 2'b01; e.imm = 2'b10;
        if (!(o inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111})) begin
            e.ill = 1'b1; e.done = 1'b1;
        end
        q.push_back(e);
        case (o)
            7'b0000011, 7'b0100011: begin
                e = blank(1'b1, z);
                e.asa = 2'b10; e.asb = 2'b01; e.imm = (o == 7'b0100011) ? 2'b01 : 2'b00;
                q.push_back(e);
                for (int i = 0; i <= mem_wait; i++) begin
                    e = blank(i == mem_wait, z);
                    e.adr = 1'b1;
                    if (o == 7'b0100011) begin
                        e.memw = 1'b1; e.done = e.mr;
                    end
                    q.push_back(e);
                end
                if (o == 7'b0000011) begin
                    e = blank(1'b1, z);
                    e.res = 2'b01; e.regw = 1'b1; e.done = 1'b1;
                    q.push_back(e);
                end
            end
            7'b0110011, 7'b0010011: begin
                e = blank(1'b1, z);
                e.asa = 2'b10; e.asb = (o == 7'b0010011) ? 2'b01 : 2'b00;
                e.aluc = model_alu(o, f3, f7);
                q.push_back(e);
                e = blank(1'b1, z);
                e.regw = 1'b1; e.done = 1'b1;
                q.push_back(e);
            end
            7'b1100011: begin
                e = blank(1'b1, z);
                e.asa = 2'b10; e.aluc = 3'b001; e.pcw = z; e.done = 1'b1;
                q.push_back(e);
            end
            7'b1101111: begin
                e = blank(1'b1, z);
                e.asa = 2'b01; e.asb = 2'b10; e.pcw = 1'b1;
                q.push_back(e);
                e = blank(1'b1, z);
                e.regw = 1'b1; e.done = 1'b1;
                q.push_back(e);
            end
            default: ;
        endcase
        op = o; fn3 = f3; fn7 = f7;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            cur       = q[i];
            cur_valid = 1'b1;
            mem_ready = q[i].mr;
            Zero      = q[i].z;
            @(posedge clk);
            #1;
        end
        cur_valid = 1'b0;
    endtask

    task automatic instr(input string tag, input logic [6:0] o, input logic [2:0] f3, input logic f7,
                         input logic z, input int fw, input int mw, input int cycles);
        cur_tag = tag;
        build(o, f3, f7, z, fw, mw);
        chk("model_cycles", q.size(), cycles);
        run(q.size());
    endtask

    initial begin
        rst = 1'b0; op = 7'd0; fn3 = 3'd0; fn7 = 1'b0; Zero = 1'b0; mem_ready = 1'b1;
        cur = '0;
        cur_tag = "reset";
        #2;
        chk("PCWrite",   PCWrite,   0);
        chk("IRWrite",   IRWrite,   0);
        chk("MemWrite",  MemWrite,  0);
        chk("RegWrite",  RegWrite,  0);
        chk("InstrDone", InstrDone, 0);
        chk("Illegal",   Illegal,   0);
        chk("AdrSrc",    AdrSrc,    0);
        chk("ALUSrcB",   ALUSrcB,   2);
        chk("ResultSrc", ResultSrc, 2);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        instr("add",  7'b0110011, 3'b000, 1'b0, 1'b0, 0, 0, 4);
        instr("lw",   7'b0000011, 3'b010, 1'b0, 1'b0, 0, 2, 7);
        instr("sw",   7'b0100011, 3'b010, 1'b0, 1'b0, 0, 1, 5);
        chk("sw_model_imm", q[2].imm, 1);
        instr("beq1", 7'b1100011, 3'b000, 1'b0, 1'b1, 0, 0, 3);
        chk("beq1_model_pcw", q[2].pcw, 1);
        instr("beq0", 7'b1100011, 3'b000, 1'b0, 1'b0, 0, 0, 3);
        instr("sub",  7'b0110011, 3'b000, 1'b1, 1'b0, 0, 0, 4);
        chk("sub_model_aluc", q[2].aluc, 1);
        instr("addi", 7'b0010011, 3'b000, 1'b1, 1'b0, 0, 0, 4);
        chk("addi_model_aluc", q[2].aluc, 0);
        instr("and",  7'b0110011, 3'b111, 1'b0, 1'b0, 0, 0, 4);
        instr("slti", 7'b0010011, 3'b010, 1'b0, 1'b1, 0, 0, 4);
        instr("or_fw2", 7'b0110011, 3'b110, 1'b0, 1'b0, 2, 0, 6);
        instr("xori", 7'b0010011, 3'b100, 1'b0, 1'b0, 0, 0, 4);
        instr("jal",  7'b1101111, 3'b000, 1'b0, 1'b0, 0, 0, 4);
        instr("ill",  7'b1111111, 3'b000, 1'b0, 1'b0, 0, 0, 2);
        chk("ill_model_flag", q[1].ill, 1);
        instr("lw_fw1", 7'b0000011, 3'b010, 1'b0, 1'b0, 1, 0, 6);

        cur_tag = "sw_reset";
        build(7'b0100011, 3'b010, 1'b0, 1'b0, 0, 3);
        run(4);
        mem_ready = 1'b0;
        #1 chk("MemWrite_waiting", MemWrite, 1);
        #2 rst = 1'b0;
        #1;
        chk("MemWrite_in_reset", MemWrite, 0);
        chk("AdrSrc_in_reset",   AdrSrc,   0);
        chk("ALUSrcB_in_reset",  ALUSrcB,  2);
        chk("InstrDone_in_reset", InstrDone, 0);
        @(posedge clk);
        #1 mem_ready = 1'b1;
        #1;
        chk("IRWrite_in_reset", IRWrite, 0);
        chk("PCWrite_in_reset", PCWrite, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        instr("add_after_reset", 7'b0110011, 3'b000, 1'b0, 1'b0, 0, 0, 4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
